// File: rtl/bv_pkg.sv
// bv_pkg: shared constants and lane-grouping helpers for the bit-vector result encoder
package bv_pkg;
  localparam int BV_NUM_LANES = 4;
  localparam int BV_VEC_WIDTH = 64;
  localparam int BV_MODE_ALL = 0;
  localparam int BV_MODE_SINGLE = $clog2(BV_NUM_LANES);
  function automatic int bv_mode_width(input int lanes);
    return (lanes > 1) ? $clog2($clog2(lanes) + 1) : 1;
  endfunction
  function automatic int bv_group_base(input int lane, input int shift);
    return (lane >> shift) << shift;
  endfunction
endpackage

// File: rtl/bv_group_result_encoder_if.sv
// bv_group_result_encoder_if: valid/ready beat bus into and out of the result encoder
interface bv_group_result_encoder_if
  import bv_pkg::*;
#(
  parameter int NUM_LANES = BV_NUM_LANES,
  parameter int BV_WIDTH = BV_VEC_WIDTH,
  parameter int BIN_WIDTH = $clog2(BV_WIDTH),
  parameter int MODE_WIDTH = bv_mode_width(NUM_LANES)
);
  logic in_valid;
  logic in_ready;
  logic [MODE_WIDTH-1:0] in_mode;
  logic [NUM_LANES*BV_WIDTH-1:0] in_bv;
  logic out_valid;
  logic out_ready;
  logic [MODE_WIDTH-1:0] out_mode;
  logic [NUM_LANES-1:0] out_hit;
  logic [NUM_LANES-1:0] out_multi;
  logic [NUM_LANES*BIN_WIDTH-1:0] out_idx;
  modport master (
    output in_valid, in_mode, in_bv, out_ready,
    input in_ready, out_valid, out_mode, out_hit, out_multi, out_idx
  );
  modport slave (
    input in_valid, in_mode, in_bv, out_ready,
    output in_ready, out_valid, out_mode, out_hit, out_multi, out_idx
  );
endinterface

// File: rtl/bv_priority_encoder.sv
// bv_priority_encoder: lowest-set-bit index plus hit / multi-hit flags for one vector
module bv_priority_encoder #(
  parameter int BV_WIDTH = 64,
  parameter int BIN_WIDTH = $clog2(BV_WIDTH)
) (
  input logic [BV_WIDTH-1:0] vec,
  output logic [BIN_WIDTH-1:0] idx,
  output logic hit,
  output logic multi
);
  always_comb begin
    idx = '0;
    for (int i = BV_WIDTH - 1; i >= 0; i--) idx = vec[i] ? BIN_WIDTH'(i) : idx;
  end
  assign hit = |vec;
  // clearing the lowest set bit leaves something only when two or more were set
  assign multi = |(vec & (vec - BV_WIDTH'(1)));
endmodule

// File: rtl/bv_group_result_encoder.sv
// bv_group_result_encoder: grouped lane AND then per-lane priority encode, 2-stage valid/ready pipe
module bv_group_result_encoder
  import bv_pkg::*;
#(
  parameter int NUM_LANES = BV_NUM_LANES,
  parameter int BV_WIDTH = BV_VEC_WIDTH,
  parameter int BIN_WIDTH = $clog2(BV_WIDTH),
  parameter int MODE_WIDTH = bv_mode_width(NUM_LANES)
) (
  input logic clk,
  input logic rst,
  bv_group_result_encoder_if.slave bus
);
  localparam int LOG_LANES = $clog2(NUM_LANES);
  logic adv;
  int eff;
  int shift;
  logic [BV_WIDTH-1:0] grp [NUM_LANES];
  logic [BV_WIDTH-1:0] s1_vec [NUM_LANES];
  logic s1_valid;
  logic [MODE_WIDTH-1:0] s1_mode;
  logic [NUM_LANES*BIN_WIDTH-1:0] enc_idx;
  logic [NUM_LANES-1:0] enc_hit;
  logic [NUM_LANES-1:0] enc_multi;
  logic out_valid;
  logic [MODE_WIDTH-1:0] out_mode;
  logic [NUM_LANES-1:0] out_hit;
  logic [NUM_LANES-1:0] out_multi;
  logic [NUM_LANES*BIN_WIDTH-1:0] out_idx;
  assign adv = !out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  // lanes share a group when their indices agree above the low 'shift' bits
  always_comb begin
    eff = (int'(bus.in_mode) > LOG_LANES) ? BV_MODE_ALL : int'(bus.in_mode);
    shift = LOG_LANES - eff;
    for (int k = 0; k < NUM_LANES; k++) begin
      grp[k] = '1;
      for (int j = 0; j < NUM_LANES; j++)
        grp[k] = (bv_group_base(j, shift) == bv_group_base(k, shift)) ? grp[k] & bus.in_bv[j*BV_WIDTH +: BV_WIDTH] : grp[k];
    end
  end
  always_ff @(posedge clk) if (adv) s1_vec <= grp;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_enc
    bv_priority_encoder #(.BV_WIDTH(BV_WIDTH), .BIN_WIDTH(BIN_WIDTH)) u_enc (
      .vec(s1_vec[k]),
      .idx(enc_idx[k*BIN_WIDTH +: BIN_WIDTH]),
      .hit(enc_hit[k]),
      .multi(enc_multi[k])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode <= '0;
      out_valid <= 1'b0;
      out_mode <= '0;
      out_hit <= '0;
      out_multi <= '0;
      out_idx <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_mode <= bus.in_mode;
      out_valid <= s1_valid;
      out_mode <= s1_mode;
      out_hit <= enc_hit;
      out_multi <= enc_multi;
      out_idx <= enc_idx;
    end
  end
  assign bus.out_valid = out_valid;
  assign bus.out_mode = out_mode;
  assign bus.out_hit = out_hit;
  assign bus.out_multi = out_multi;
  assign bus.out_idx = out_idx;
endmodule

// File: tb/tb_bv_group_result_encoder.sv
// tb_bv_group_result_encoder: directed beats with a scoreboard queue checked by a negedge monitor
module tb_bv_group_result_encoder;
  localparam int NL = 4;
  localparam int W = 64;
  typedef struct {
    logic [1:0] mode;
    logic [3:0] hit;
    logic [3:0] multi;
    logic [23:0] idx;
    int acc;
    bit lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;
  logic stalled = 1'b0;
  logic [33:0] snap;
  logic [33:0] pl;
  bv_group_result_encoder_if #(.NUM_LANES(NL), .BV_WIDTH(W)) bus ();
  bv_group_result_encoder #(.NUM_LANES(NL), .BV_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pl = {bus.out_mode, bus.out_hit, bus.out_multi, bus.out_idx};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic exp_t mk(input logic [1:0] m, input logic [3:0] h, input logic [3:0] mu,
                              input int i0, input int i1, input int i2, input int i3, input bit lat);
    exp_t r;
    r.mode = m;
    r.hit = h;
    r.multi = mu;
    r.idx = {6'(i3), 6'(i2), 6'(i1), 6'(i0)};
    r.acc = 0;
    r.lat = lat;
    return r;
  endfunction
  function automatic logic [255:0] ln(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction
  // called at posedge+2; records the cycle the beat is presented with in_ready high
  task automatic send(input logic [1:0] m, input logic [255:0] bv, input exp_t x, input bit push);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_mode = m;
    bus.in_bv = bv;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("accept_timeout", 64'(n < 50), 1);
    x.acc = cyc;
    if (push) q.push_back(x);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain", 64'(q.size()), 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (stalled) chk("stall_hold", {bus.out_valid, pl}, {1'b1, snap});
      if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", 64'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_expected", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("beat", 64'(pl), 64'({e.mode, e.hit, e.multi, e.idx}));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 2);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      snap = pl;
    end else stalled = 1'b0;
  end
  initial begin
    logic [255:0] v5;
    bus.in_valid = 1'b0;
    bus.in_mode = '0;
    bus.in_bv = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_out_valid", 64'(bus.out_valid), 0);
    chk("reset_payload", 64'(pl), 0);
    chk("reset_in_ready", 64'(bus.in_ready), 1);
    send(2'd0, ln(64'hF0, 64'h30, 64'h10, 64'hFF), mk(2'd0, 4'hF, 4'h0, 4, 4, 4, 4, 1), 1);
    send(2'd1, ln(64'h200, 64'h200, 64'h8, 64'h20), mk(2'd1, 4'b0011, 4'h0, 9, 9, 0, 0, 1), 1);
    send(2'd2, ln(64'h8000_0000_0000_0001, 64'h0, 64'h6, 64'h8000_0000_0000_0000),
         mk(2'd2, 4'b1101, 4'b0101, 0, 0, 1, 63, 1), 1);
    v5 = ln(64'h0010_0081, 64'h0010_0182, 64'h0010_0380, 64'h0010_FF80);
    send(2'd3, v5, mk(2'd3, 4'hF, 4'hF, 7, 7, 7, 7, 1), 1);
    send(2'd0, v5, mk(2'd0, 4'hF, 4'hF, 7, 7, 7, 7, 1), 1);
    drain();
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      for (int b = 0; b < 6; b++)
        send(2'd2, ln(64'd1 << (b*8), 64'd1 << (b*8+1), 64'd1 << (b*8+2), 64'd1 << (b*8+3)),
             mk(2'd2, 4'hF, 4'h0, b*8, b*8+1, b*8+2, b*8+3, 0), 1);
    join
    drain();
    bus.out_ready = 1'b0;
    send(2'd0, ln(64'h1, 64'h1, 64'h1, 64'h1), mk(2'd0, 4'hF, 4'h0, 0, 0, 0, 0, 0), 0);
    send(2'd2, ln(64'h2, 64'h2, 64'h2, 64'h2), mk(2'd2, 4'hF, 4'h0, 1, 1, 1, 1, 0), 0);
    chk("inflight_valid", 64'(bus.out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_payload", 64'(pl), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      chk("no_stale_valid", 64'(bus.out_valid), 0);
    end
    send(2'd2, ln(64'h0, 64'h8000_0000_0000_0000, 64'hC, 64'h1),
         mk(2'd2, 4'b1110, 4'b0100, 0, 63, 2, 0, 1), 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
